regfile_wb_arbiter: RTL

Shares the single register-file write port between two write-back requesters: A (ALU result path) and B (load/memory result path). Each requester has a one-entry holding buffer with a valid/ready handshake. A round-robin arbiter, with an ordering rule for same-address writes, drives the register-file write port from registered outputs. It also exports a pending-write mask so decode can stall on read-after-write hazards, and flags out-of-range write addresses.

---
 rtl/regfile_wb_arbiter.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the single register-file write port.
// Two requesters (A: ALU results, B: load results) each own a one-entry
// holding buffer. A round-robin arbiter picks which buffer drives the
// registered write port. When both buffers target the same register, the
// older buffer always goes first, so program order is kept for that register.
// The block also exports a pending-write mask for hazard detection and a
// sticky out-of-range address flag.

module regfile_wb_arbiter #(
   parameter int NUM_REGS    = 11,
   parameter bit ZERO_REG_RO = 1'b1,
   parameter int DATA_W      = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                a_valid,
   output logic                a_ready,
   input  logic [4:0]          a_addr,
   input  logic [DATA_W-1:0]   a_data,
   input  logic                b_valid,
   output logic                b_ready,
   input  logic [4:0]          b_addr,
   input  logic [DATA_W-1:0]   b_data,
   output logic                rf_write_en,
   output logic [4:0]          rf_write_addr,
   output logic [DATA_W-1:0]   rf_write_data,
   output logic [NUM_REGS-1:0] pending_mask,
   output logic                err_addr
);

   typedef enum logic {
      SIDE_A = 1'b0,
      SIDE_B = 1'b1
   } side_t;

   localparam logic [5:0] REG_LIMIT = 6'(NUM_REGS);

   logic              a_buf_valid;
   logic [4:0]        a_buf_addr;
   logic [DATA_W-1:0] a_buf_data;
   logic              b_buf_valid;
   logic [4:0]        b_buf_addr;
   logic [DATA_W-1:0] b_buf_data;

   side_t             rr_ptr;
   side_t             older;

   logic              load_a;
   logic              load_b;
   logic              grant_a;
   logic              grant_b;
   logic              contested;
   logic              any_grant;
   logic [4:0]        win_addr;
   logic [DATA_W-1:0] win_data;
   logic              win_legal;
   logic              win_zero_drop;

   function automatic logic [NUM_REGS-1:0] onehot(input logic [4:0] addr);
      logic [NUM_REGS-1:0] vec;
      vec = {{(NUM_REGS-1){1'b0}}, 1'b1} << addr;
      if ({1'b0, addr} >= REG_LIMIT) begin
         vec = '0;
      end
      return vec;
   endfunction

   assign a_ready = ~a_buf_valid & ~rst;
   assign b_ready = ~b_buf_valid & ~rst;
   assign load_a  = a_valid & a_ready;
   assign load_b  = b_valid & b_ready;

   // Pick a winner from the buffer contents as they stand before this edge's
   // loads: same-register writes go oldest first, otherwise the rr pointer decides.
   always_comb begin
      grant_a   = 1'b0;
      grant_b   = 1'b0;
      contested = 1'b0;
      if (a_buf_valid && b_buf_valid) begin
         if (a_buf_addr == b_buf_addr) begin
            grant_a = (older == SIDE_A);
         end else begin
            contested = 1'b1;
            grant_a   = (rr_ptr == SIDE_A);
         end
         grant_b = ~grant_a;
      end else begin
         grant_a = a_buf_valid;
         grant_b = b_buf_valid;
      end
   end

   // Route the winning buffer to the port and classify its address.
   always_comb begin
      any_grant     = grant_a | grant_b;
      win_addr      = grant_a ? a_buf_addr : b_buf_addr;
      win_data      = grant_a ? a_buf_data : b_buf_data;
      win_legal     = ({1'b0, win_addr} < REG_LIMIT);
      win_zero_drop = ZERO_REG_RO && (win_addr == 5'd0);
   end

   // Requester A holding buffer: load when empty, drain when granted.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_buf_valid <= 1'b0;
         a_buf_addr  <= '0;
         a_buf_data  <= '0;
      end else if (load_a) begin
         a_buf_valid <= 1'b1;
         a_buf_addr  <= a_addr;
         a_buf_data  <= a_data;
      end else if (grant_a) begin
         a_buf_valid <= 1'b0;
      end
   end

   // Requester B holding buffer: same behaviour as A.
   always_ff @(posedge clk) begin
      if (rst) begin
         b_buf_valid <= 1'b0;
         b_buf_addr  <= '0;
         b_buf_data  <= '0;
      end else if (load_b) begin
         b_buf_valid <= 1'b1;
         b_buf_addr  <= b_addr;
         b_buf_data  <= b_data;
      end else if (grant_b) begin
         b_buf_valid <= 1'b0;
      end
   end

   // Track which buffer holds the earlier write; a tie favours A.
   always_ff @(posedge clk) begin
      if (rst) begin
         older <= SIDE_A;
      end else if (load_a && load_b) begin
         older <= SIDE_A;
      end else if (load_a && b_buf_valid) begin
         older <= SIDE_B;
      end else if (load_b && a_buf_valid) begin
         older <= SIDE_A;
      end
   end

   // Round-robin pointer only moves when two different registers compete.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr <= SIDE_A;
      end else if (contested) begin
         rr_ptr <= grant_a ? SIDE_B : SIDE_A;
      end
   end

   // Registered write port; illegal and read-only-zero writes consume the
   // grant but leave the strobe low.
   always_ff @(posedge clk) begin
      if (rst) begin
         rf_write_en   <= 1'b0;
         rf_write_addr <= '0;
         rf_write_data <= '0;
      end else if (any_grant) begin
         rf_write_en   <= win_legal & ~win_zero_drop;
         rf_write_addr <= win_addr;
         rf_write_data <= win_data;
      end else begin
         rf_write_en   <= 1'b0;
      end
   end

   // Sticky flag for any granted write aimed past the last register.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_addr <= 1'b0;
      end else if (any_grant && !win_legal) begin
         err_addr <= 1'b1;
      end
   end

   // Registers with a write still buffered or on the port, for decode stalls.
   always_comb begin
      pending_mask = '0;
      if (a_buf_valid) begin
         pending_mask = pending_mask | onehot(a_buf_addr);
      end
      if (b_buf_valid) begin
         pending_mask = pending_mask | onehot(b_buf_addr);
      end
      if (rf_write_en) begin
         pending_mask = pending_mask | onehot(rf_write_addr);
      end
   end

endmodule
